alu_input_sequencer: RTL and testbench
======================================

# alu_input_sequencer

Upstream front-end for the board-level ALU control FSM. Debounces the two raw push buttons and captures operand A, operand B and the operation code from the 2-bit switch banks in a fixed sequence. It then issues the one-cycle `handshaking` pulse and the one-cycle `confirm_op` pulse that the ALU FSM consumes. Operand and opcode outputs are registered and stay stable from capture until the next capture of the same field.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronized-stable cycles required before a button level is accepted; must be ≥ 2. Board builds override this with a large value; simulation uses the default.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `btn_next`  in  1  raw, asynchronous, bouncy "load next field" button; active-high.
- `btn_confirm`  in  1  raw, asynchronous, bouncy "confirm operation" button; active-high.
- `sw_data`  in  2  operand switches.
- `sw_op`  in  2  opcode switches.
- `operand_a`  out  2  captured operand A.
- `operand_b`  out  2  captured operand B.
- `switch_op`  out  2  captured opcode.
- `handshaking`  out  1  registered one-cycle pulse: a complete operation is loaded.
- `confirm_op`  out  1  registered one-cycle pulse: the operation is confirmed.
- `seq_state`  out  2  current sequencer state, for LEDs.

## Operation
- **Per-button front end:**
  - 2-flop synchronizer.
  - Debounce counter: counts cycles in which the synchronized level differs from the accepted level. The counter clears whenever the two levels agree.
  - When the level has differed for `DEBOUNCE_CYCLES` consecutive cycles, the accepted level flips.
  - A press event is the 0→1 transition of the accepted level. It lasts one cycle. Release transitions generate no event.
- **FSM states:** LOAD_A=00, LOAD_B=01, READY=10, HANDOFF=11. `seq_state` equals the state register.
- **LOAD_A:** on a `btn_next` event, `operand_a`←`sw_data` and the FSM moves to LOAD_B.
- **LOAD_B:** on a `btn_next` event, `operand_b`←`sw_data`, `switch_op`←`sw_op`, `handshaking`←1 for one cycle, and the FSM moves to READY.
- **READY:** on a `btn_confirm` event, `confirm_op`←1 for one cycle and the FSM moves to HANDOFF. `btn_next` events are ignored.
- **HANDOFF:** lasts exactly 2 cycles so the downstream execute cycle sees stable operands, then the FSM moves to LOAD_A. All button events are ignored.
- **Events outside their accepting state:** `btn_confirm` events in LOAD_A, LOAD_B and HANDOFF are discarded. Events are never queued.
- **Simultaneous events:** a `btn_next` and a `btn_confirm` event in the same cycle are each evaluated only against the current state. At most one of them is acted on.
- **Operand retention:** operands are never cleared except by reset. Stale values remain visible until overwritten.

## Timing
- **Reset values:** all outputs 0, state LOAD_A, accepted levels 0, counters 0, synchronizers 0.
- **Reset mid-operation:** takes effect at the next edge. Partial captures are discarded. Any pending pulse is suppressed.
- **Button held through reset:** once reset deasserts, a held button produces one press event after the normal latency and is acted on.
- **Latency:** let edge E0 be the first edge that samples a raw button high and the button stays high. The resulting register update or pulse appears at edge E0+`DEBOUNCE_CYCLES`+3.
- **Glitch rejection:** a raw pulse or bounce shorter than `DEBOUNCE_CYCLES` synchronized cycles produces no event.
- **Pulse width:** `handshaking` and `confirm_op` are each high for exactly one cycle, and never in the same cycle.
- **Minimum spacing:** at least one cycle from `handshaking` to `confirm_op` (two with auto-confirm).

## Configuration
- `ALU_SEQ_AUTO_CONFIRM_EN`
  - **Defined:** READY asserts `confirm_op` automatically on its 2nd cycle (`handshaking` at cycle t gives `confirm_op` at t+2). The `btn_confirm` path is ignored and its debouncer may be optimized away.
  - **Undefined:** confirmation requires a debounced `btn_confirm` event, as described in Operation.

## Test plan
- **Full sequence:** `DEBOUNCE_CYCLES`=4. Sequence:
  - `sw_data`=01, press `btn_next`, then check `operand_a`=01 exactly 7 edges after sampling.
  - `sw_data`=10, `sw_op`=11, press `btn_next`, then check `operand_b`=10, `switch_op`=11, one-cycle `handshaking`, and `seq_state`=10.
  - Press `btn_confirm`, then check one-cycle `confirm_op`; `seq_state` reads 11 for 2 cycles, then 00.
- **Bounce rejection:** raw `btn_next` toggles 1,0,1,0 every cycle and then holds 1 → exactly one capture. A 3-cycle glitch → no capture, `operand_a` unchanged.
- **Out-of-state and simultaneous events:**
  - `btn_confirm` pressed in LOAD_A → no `confirm_op`, state stays 00.
  - `btn_next` pressed in READY → operands unchanged.
  - Both buttons pressed together in READY → only `confirm_op`.
- **Reset mid-sequence:** assert `reset` for one cycle in READY → all outputs 00/0 on the next edge, state 00. A `btn_next` held across reset captures once, 7 edges after release.
- **Auto-confirm build:** with `ALU_SEQ_AUTO_CONFIRM_EN` defined, after the LOAD_B capture, `confirm_op` fires 2 cycles after `handshaking` with `btn_confirm` held 0.

Source files
------------

// File: rtl/alu_input_sequencer.sv
// Button front end and capture sequencer feeding the board ALU control FSM.
// Optional build macro ALU_SEQ_AUTO_CONFIRM_EN: confirm automatically on the second READY cycle.

module alu_input_sequencer_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic press
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          level_q, level_d;
   logic          level_prev_q, level_prev_d;
   logic          press_q, press_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // NOTE: every variable gets a default before any branch, so no path leaves it unassigned (no latch).
   always_comb begin
      sync1_d      = btn_raw;
      sync2_d      = sync1_q;
      level_d      = level_q;
      cnt_d        = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            level_d = ~level_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      level_prev_d = level_q;
      press_d      = level_q & ~level_prev_q;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         level_q      <= 1'b0;
         level_prev_q <= 1'b0;
         press_q      <= 1'b0;
         cnt_q        <= '0;
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         level_q      <= level_d;
         level_prev_q <= level_prev_d;
         press_q      <= press_d;
         cnt_q        <= cnt_d;
      end
   end

   assign press = press_q;

endmodule

module alu_input_sequencer #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_next,
   input  logic       btn_confirm,
   input  logic [1:0] sw_data,
   input  logic [1:0] sw_op,
   output logic [1:0] operand_a,
   output logic [1:0] operand_b,
   output logic [1:0] switch_op,
   output logic       handshaking,
   output logic       confirm_op,
   output logic [1:0] seq_state
);

   typedef enum logic [1:0] {
      LOAD_A  = 2'b00,
      LOAD_B  = 2'b01,
      READY   = 2'b10,
      HANDOFF = 2'b11
   } state_e;

   state_e     state_q, state_d;
   logic [1:0] operand_a_q, operand_a_d;
   logic [1:0] operand_b_q, operand_b_d;
   logic [1:0] switch_op_q, switch_op_d;
   logic       handshaking_q, handshaking_d;
   logic       confirm_op_q, confirm_op_d;
   logic       phase_q, phase_d;
   logic       next_press;

   alu_input_sequencer_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next_db (
      .clk     (clk),
      .reset   (reset),
      .btn_raw (btn_next),
      .press   (next_press)
   );

`ifndef ALU_SEQ_AUTO_CONFIRM_EN
   logic confirm_press;

   alu_input_sequencer_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_confirm_db (
      .clk     (clk),
      .reset   (reset),
      .btn_raw (btn_confirm),
      .press   (confirm_press)
   );
`endif

   // phase_q marks the second cycle of a two-cycle state; it clears on every state entry.
   always_comb begin
      state_d       = state_q;
      operand_a_d   = operand_a_q;
      operand_b_d   = operand_b_q;
      switch_op_d   = switch_op_q;
      handshaking_d = 1'b0;
      confirm_op_d  = 1'b0;
      phase_d       = 1'b0;
      case (state_q)
         LOAD_A: begin
            if (next_press) begin
               operand_a_d = sw_data;
               state_d     = LOAD_B;
            end
         end
         LOAD_B: begin
            if (next_press) begin
               operand_b_d   = sw_data;
               switch_op_d   = sw_op;
               handshaking_d = 1'b1;
               state_d       = READY;
            end
         end
         READY: begin
`ifdef ALU_SEQ_AUTO_CONFIRM_EN
            if (phase_q) begin
               confirm_op_d = 1'b1;
               state_d      = HANDOFF;
            end else begin
               phase_d = 1'b1;
            end
`else
            if (confirm_press) begin
               confirm_op_d = 1'b1;
               state_d      = HANDOFF;
            end
`endif
         end
         HANDOFF: begin
            if (phase_q) begin
               state_d = LOAD_A;
            end else begin
               phase_d = 1'b1;
            end
         end
         default: state_d = LOAD_A;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= LOAD_A;
         operand_a_q   <= 2'b00;
         operand_b_q   <= 2'b00;
         switch_op_q   <= 2'b00;
         handshaking_q <= 1'b0;
         confirm_op_q  <= 1'b0;
         phase_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         operand_a_q   <= operand_a_d;
         operand_b_q   <= operand_b_d;
         switch_op_q   <= switch_op_d;
         handshaking_q <= handshaking_d;
         confirm_op_q  <= confirm_op_d;
         phase_q       <= phase_d;
      end
   end

   assign operand_a   = operand_a_q;
   assign operand_b   = operand_b_q;
   assign switch_op   = switch_op_q;
   assign handshaking = handshaking_q;
   assign confirm_op  = confirm_op_q;
   assign seq_state   = state_q;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Scoreboard bench for alu_input_sequencer: stimulus pushes predicted output events, a monitor pops them.
module tb_alu_input_sequencer;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       btn_next = 1'b0;
   logic       btn_confirm = 1'b0;
   logic [1:0] sw_data = 2'b00;
   logic [1:0] sw_op = 2'b00;
   logic [1:0] operand_a, operand_b, switch_op, seq_state;
   logic       handshaking, confirm_op;

   alu_input_sequencer #(.DEBOUNCE_CYCLES(D)) dut (
      .clk         (clk),
      .reset       (reset),
      .btn_next    (btn_next),
      .btn_confirm (btn_confirm),
      .sw_data     (sw_data),
      .sw_op       (sw_op),
      .operand_a   (operand_a),
      .operand_b   (operand_b),
      .switch_op   (switch_op),
      .handshaking (handshaking),
      .confirm_op  (confirm_op),
      .seq_state   (seq_state)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      int         t;
      logic [1:0] st, a, b, op;
      logic       hs, conf;
   } exp_t;

   exp_t sb[$];

   // Behavioural model: abstract phase plus captured fields, advanced per accepted press.
   int         m_st = 0;
   logic [1:0] m_a = 0, m_b = 0, m_op = 0;
   int         m_hoff_end = 0;

   function automatic void model_now(input int t);
      if (m_st == 3 && t >= m_hoff_end) m_st = 0;
   endfunction

   function automatic void push(input int t, input int st, input logic hs, input logic conf);
      exp_t e;
      e.t = t; e.st = 2'(st); e.a = m_a; e.b = m_b; e.op = m_op; e.hs = hs; e.conf = conf;
      sb.push_back(e);
   endfunction

   function automatic void model_act(input bit n, input bit c, input int t);
      model_now(t);
      case (m_st)
         0: if (n) begin
            m_a = sw_data; m_st = 1; push(t, 1, 1'b0, 1'b0);
         end
         1: if (n) begin
            m_b = sw_data; m_op = sw_op; m_st = 2; push(t, 2, 1'b1, 1'b0);
`ifdef ALU_SEQ_AUTO_CONFIRM_EN
            push(t + 2, 3, 1'b0, 1'b1);
            push(t + 4, 0, 1'b0, 1'b0);
            m_st = 3; m_hoff_end = t + 4;
`endif
         end
         2: begin
`ifndef ALU_SEQ_AUTO_CONFIRM_EN
            if (c) begin
               push(t, 3, 1'b0, 1'b1);
               push(t + 2, 0, 1'b0, 1'b0);
               m_st = 3; m_hoff_end = t + 2;
            end
`endif
         end
         default: ;
      endcase
   endfunction

   // Monitor: any state/operand change or pulse is an output event and must match the queue head.
   bit         mon_en = 0;
   logic [1:0] p_st, p_a, p_b, p_op;
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         if (seq_state !== p_st || operand_a !== p_a || operand_b !== p_b ||
             switch_op !== p_op || handshaking || confirm_op) begin
            if (sb.size() == 0) begin
               check("event_expected", 32'(sb.size() > 0), 32'd1);
            end else begin
               e = sb.pop_front();
               check("ev_cycle", 32'(cyc), 32'(e.t));
               check("ev_state", 32'(seq_state), 32'(e.st));
               check("ev_operand_a", 32'(operand_a), 32'(e.a));
               check("ev_operand_b", 32'(operand_b), 32'(e.b));
               check("ev_switch_op", 32'(switch_op), 32'(e.op));
               check("ev_handshaking", 32'(handshaking), 32'(e.hs));
               check("ev_confirm_op", 32'(confirm_op), 32'(e.conf));
            end
         end
      end
      p_st = seq_state; p_a = operand_a; p_b = operand_b; p_op = switch_op;
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_btns(input bit n, input bit c, input bit v);
      btn_next    = n & v;
      btn_confirm = c & v;
   endtask

   task automatic check_quiet();
      model_now(cyc);
      check("quiet_state", 32'(seq_state), 32'(m_st));
      check("quiet_operand_a", 32'(operand_a), 32'(m_a));
      check("quiet_operand_b", 32'(operand_b), 32'(m_b));
      check("quiet_switch_op", 32'(switch_op), 32'(m_op));
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_state"}, 32'(seq_state), 32'd0);
      check({tag, "_operand_a"}, 32'(operand_a), 32'd0);
      check({tag, "_operand_b"}, 32'(operand_b), 32'd0);
      check({tag, "_switch_op"}, 32'(switch_op), 32'd0);
      check({tag, "_handshaking"}, 32'(handshaking), 32'd0);
      check({tag, "_confirm_op"}, 32'(confirm_op), 32'd0);
   endtask

   // Optional short bounces, then a clean hold; the accepted press acts D+3 edges after the hold starts.
   task automatic press(input bit n, input bit c, input int nb, input int bl, input int hold);
      for (int k = 0; k < nb; k++) begin
         set_btns(n, c, 1'b1); wait_cyc(bl);
         set_btns(n, c, 1'b0); wait_cyc(1);
      end
      set_btns(n, c, 1'b1);
      model_act(n, c, cyc + 1 + D + 3);
      wait_cyc(hold);
      set_btns(n, c, 1'b0);
      wait_cyc(D + 10);
      check_quiet();
   endtask

   task automatic glitch(input bit n, input bit c, input int len);
      set_btns(n, c, 1'b1); wait_cyc(len);
      set_btns(n, c, 1'b0); wait_cyc(D + 10);
      check_quiet();
   endtask

   task automatic reset_with_held_next();
      int  t_r;
      bit  dirty;
      t_r = cyc + 1;
      model_now(t_r);
      dirty = (m_st != 0) || (m_a != 0) || (m_b != 0) || (m_op != 0);
      m_st = 0; m_a = 0; m_b = 0; m_op = 0;
      if (dirty) push(t_r, 0, 1'b0, 1'b0);
      reset = 1'b1; btn_next = 1'b1; btn_confirm = 1'b0;
      wait_cyc(1);
      reset = 1'b0;
      check_zero("mid_reset");
      model_act(1'b1, 1'b0, cyc + 1 + D + 3);
      wait_cyc(12);
      btn_next = 1'b0;
      wait_cyc(D + 10);
      check_quiet();
   endtask

   initial begin
      wait_cyc(3);
      reset = 1'b0;
      check_zero("reset");
      mon_en = 1;

      // Full sequence.
      sw_data = 2'b01;                 press(1'b1, 1'b0, 0, 1, 10);
      sw_data = 2'b10; sw_op = 2'b11;  press(1'b1, 1'b0, 0, 1, 10);
      press(1'b0, 1'b1, 0, 1, 10);

      // Confirm outside READY, bounce on next, short glitch.
      press(1'b0, 1'b1, 0, 1, 10);
      sw_data = 2'b11;                 press(1'b1, 1'b0, 2, 1, 10);
      sw_data = 2'b00;                 glitch(1'b1, 1'b0, 3);

      // Next ignored in READY; simultaneous press in READY confirms only.
      sw_data = 2'b00; sw_op = 2'b01;  press(1'b1, 1'b0, 0, 1, 9);
      sw_data = 2'b10; sw_op = 2'b10;  press(1'b1, 1'b0, 0, 1, 9);
      press(1'b1, 1'b1, 0, 1, 9);

      // Reach READY again, then reset with next held through it.
      sw_data = 2'b01;                 press(1'b1, 1'b0, 1, 2, 9);
      sw_data = 2'b11; sw_op = 2'b01;  press(1'b1, 1'b0, 0, 1, 9);
      sw_data = 2'b10;                 reset_with_held_next();

      for (int i = 0; i < 30; i++) begin
         int kind;
         kind    = $urandom_range(0, 9);
         sw_data = 2'($urandom_range(0, 3));
         sw_op   = 2'($urandom_range(0, 3));
         case (kind)
            0, 1, 2, 3, 4: press(1'b1, 1'b0, 0, 1, $urandom_range(8, 14));
            5, 6:          press(1'b0, 1'b1, $urandom_range(0, 2), $urandom_range(1, D - 1), $urandom_range(8, 14));
            7:             press(1'b1, 1'b1, 0, 1, $urandom_range(8, 14));
            8:             glitch($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(1, D - 1));
            default:       press(1'b1, 1'b0, $urandom_range(1, 3), $urandom_range(1, D - 1), $urandom_range(8, 14));
         endcase
      end

      for (int k = 0; k < 50 && sb.size() != 0; k++) wait_cyc(1);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
